fir_coeff_loader: RTL and testbench

Write-side companion to the 4-tap systolic preadd FIR. It accepts coefficient writes over a valid/ready interface into a shadow bank. On commit it applies all four 18-bit coefficients to the filter in one cycle. It then holds the filter DSPs in reset for a flush window, so no output sample ever mixes old and new coefficients.

---
 rtl/fir_coeff_pkg.sv | 23 ++
 rtl/fir_coeff_loader_if.sv | 42 ++++
 rtl/fir_coeff_bank.sv | 40 ++++
 rtl/fir_coeff_loader.sv | 141 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared widths, types and FSM encoding for the FIR coefficient loader.
package fir_coeff_pkg;

    localparam int unsigned COEFF_BITS    = 18;
    localparam int unsigned NTAPS         = 4;
    localparam int unsigned TAP_ADDR_BITS = 2;
    localparam int unsigned BANK_BITS     = COEFF_BITS * NTAPS;

    typedef logic signed [COEFF_BITS-1:0] coeff_t;
    typedef logic [TAP_ADDR_BITS-1:0]     tap_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        FLUSH = 2'd2
    } loader_state_t;

    // Tap n of a packed coefficient bank.
    function automatic coeff_t init_tap(input logic [BANK_BITS-1:0] init, input int unsigned n);
        return $signed(init[n*COEFF_BITS +: COEFF_BITS]);
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Write/commit bus and filter-side coefficient outputs of the loader.
// FIR_COEFF_LOADER_READBACK_EN adds the readback port.
interface fir_coeff_loader_if;
    import fir_coeff_pkg::*;

    logic      wr_valid_i;
    logic      wr_ready_o;
    tap_addr_t wr_addr_i;
    coeff_t    wr_data_i;
    logic      commit_i;
    logic      busy_o;
    logic      done_o;
    coeff_t    coeff0_o;
    coeff_t    coeff1_o;
    coeff_t    coeff2_o;
    coeff_t    coeff3_o;
    logic      dsp_rst_o;
`ifdef FIR_COEFF_LOADER_READBACK_EN
    tap_addr_t rd_addr_i;
    logic [0:0] rd_sel_i;
    coeff_t    rd_data_o;
`endif

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, commit_i,
`ifdef FIR_COEFF_LOADER_READBACK_EN
        output rd_addr_i, rd_sel_i,
        input  rd_data_o,
`endif
        input  wr_ready_o, busy_o, done_o, coeff0_o, coeff1_o, coeff2_o, coeff3_o, dsp_rst_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, commit_i,
`ifdef FIR_COEFF_LOADER_READBACK_EN
        input  rd_addr_i, rd_sel_i,
        output rd_data_o,
`endif
        output wr_ready_o, busy_o, done_o, coeff0_o, coeff1_o, coeff2_o, coeff3_o, dsp_rst_o
    );

endinterface

// File: rtl/fir_coeff_bank.sv
// 4x18 coefficient register bank: single-tap write, whole-bank load, parallel out.
// FIR_COEFF_LOADER_READBACK_EN adds a combinational read mux.
module fir_coeff_bank
    import fir_coeff_pkg::*;
#(
    parameter logic [BANK_BITS-1:0] INIT_COEFF = '0
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      wr_en,
    input  tap_addr_t wr_addr,
    input  coeff_t    wr_data,
    input  logic      load_en,
    input  coeff_t    load_data [NTAPS],
    output coeff_t    q [NTAPS]
`ifdef FIR_COEFF_LOADER_READBACK_EN
    ,
    input  tap_addr_t rd_addr,
    output coeff_t    rd_word_c
`endif
);

    // Whole-bank load takes priority over a single-tap write.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                q[i] <= init_tap(INIT_COEFF, i);
            end
        end else if (load_en) begin
            q <= load_data;
        end else if (wr_en) begin
            q[wr_addr] <= wr_data;
        end
    end

`ifdef FIR_COEFF_LOADER_READBACK_EN
    assign rd_word_c = q[rd_addr];
`endif

endmodule

// File: rtl/fir_coeff_loader.sv
// Shadow/active coefficient loader for the 4-tap systolic FIR with post-apply DSP flush.
// FIR_COEFF_LOADER_READBACK_EN adds a registered shadow/active readback port.
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int unsigned          FLUSH_CYCLES = 8,
    parameter logic [BANK_BITS-1:0] INIT_COEFF   = '0
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    fir_coeff_loader_if.slave  bus
);

    localparam int unsigned CNT_BITS = 8;

    loader_state_t       state;
    logic [CNT_BITS-1:0] flush_cnt;
    logic                dirty;
    logic                post_reset;
    logic                wr_ready;
    logic                busy;
    logic                done;
    logic                dsp_rst;

    coeff_t shadow_q [NTAPS];
    coeff_t active_q [NTAPS];

    logic accept_c;
    assign accept_c = bus.wr_valid_i & wr_ready;

`ifdef FIR_COEFF_LOADER_READBACK_EN
    coeff_t shadow_rd_c;
    coeff_t active_rd_c;
    coeff_t rd_data;
`endif

    fir_coeff_bank #(.INIT_COEFF(INIT_COEFF)) u_shadow (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en     (accept_c),
        .wr_addr   (bus.wr_addr_i),
        .wr_data   (bus.wr_data_i),
        .load_en   (1'b0),
        .load_data (active_q),
        .q         (shadow_q)
`ifdef FIR_COEFF_LOADER_READBACK_EN
        ,
        .rd_addr   (bus.rd_addr_i),
        .rd_word_c (shadow_rd_c)
`endif
    );

    // A write in the commit cycle lands in shadow before APPLY copies it.
    fir_coeff_bank #(.INIT_COEFF(INIT_COEFF)) u_active (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en     (1'b0),
        .wr_addr   (bus.wr_addr_i),
        .wr_data   (bus.wr_data_i),
        .load_en   (state == APPLY),
        .load_data (shadow_q),
        .q         (active_q)
`ifdef FIR_COEFF_LOADER_READBACK_EN
        ,
        .rd_addr   (bus.rd_addr_i),
        .rd_word_c (active_rd_c)
`endif
    );

    // Control FSM; the post-reset flush ends without a done pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= FLUSH;
            flush_cnt  <= CNT_BITS'(FLUSH_CYCLES);
            dirty      <= 1'b0;
            post_reset <= 1'b1;
            wr_ready   <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            dsp_rst    <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept_c) begin
                        dirty <= 1'b1;
                    end
                    if (bus.commit_i) begin
                        if (dirty || accept_c) begin
                            state    <= APPLY;
                            wr_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    dirty     <= 1'b0;
                    dsp_rst   <= 1'b1;
                    flush_cnt <= CNT_BITS'(FLUSH_CYCLES);
                    state     <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt == CNT_BITS'(1)) begin
                        state      <= IDLE;
                        dsp_rst    <= 1'b0;
                        wr_ready   <= 1'b1;
                        busy       <= 1'b0;
                        done       <= ~post_reset;
                        post_reset <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_COEFF_LOADER_READBACK_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_data <= '0;
        end else begin
            rd_data <= bus.rd_sel_i[0] ? active_rd_c : shadow_rd_c;
        end
    end
    assign bus.rd_data_o = rd_data;
`endif

    assign bus.wr_ready_o = wr_ready;
    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
    assign bus.dsp_rst_o  = dsp_rst;
    assign bus.coeff0_o   = active_q[0];
    assign bus.coeff1_o   = active_q[1];
    assign bus.coeff2_o   = active_q[2];
    assign bus.coeff3_o   = active_q[3];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a commit-timeline reference model.
module tb_fir_coeff_loader;

    localparam int unsigned F    = 8;
    localparam logic [71:0] INIT = {18'h0, 18'h00100, 18'h0, 18'h0};

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;

    fir_coeff_loader_if bus();

    fir_coeff_loader #(.FLUSH_CYCLES(F), .INIT_COEFF(INIT)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: per-edge timeline of commits (apply edge, free edge).
    logic [17:0] m_sh  [4];
    logic [17:0] m_act [4];
    bit          m_dirty, m_idle, m_done, m_from_reset;
    int          cyc, m_apply, m_free;

    task automatic model_reset();
        logic [71:0] iv;
        iv = INIT;
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = iv[18*i +: 18];
            m_act[i] = iv[18*i +: 18];
        end
        m_dirty = 0; m_idle = 0; m_done = 0; m_from_reset = 1;
        cyc = 0; m_apply = 0; m_free = F;
    endtask

    task automatic model_step();
        cyc++;
        m_done = 0;
        if (m_idle) begin
            if (bus.wr_valid_i) begin
                m_sh[bus.wr_addr_i] = bus.wr_data_i;
                m_dirty = 1;
            end
            if (bus.commit_i) begin
                if (m_dirty) begin
                    m_idle = 0; m_apply = cyc + 1; m_free = cyc + 1 + F; m_from_reset = 0;
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            if (cyc == m_apply) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                m_dirty = 0;
            end
            if (cyc == m_free) begin
                m_idle = 1;
                m_done = !m_from_reset;
            end
        end
    endtask

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_step();
        @(negedge clk);
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [17:0] d);
        bus.wr_valid_i = 1'b1; bus.wr_addr_i = a; bus.wr_data_i = d;
        tick();
        bus.wr_valid_i = 1'b0;
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_ready", 18'(bus.wr_ready_o), 18'(m_idle));
            chk("busy",     18'(bus.busy_o),     18'(!m_idle));
            chk("dsp_rst",  18'(bus.dsp_rst_o),  18'(!m_idle && cyc >= m_apply));
            chk("done",     18'(bus.done_o),     18'(m_done));
            chk("coeff0",   bus.coeff0_o, m_act[0]);
            chk("coeff1",   bus.coeff1_o, m_act[1]);
            chk("coeff2",   bus.coeff2_o, m_act[2]);
            chk("coeff3",   bus.coeff3_o, m_act[3]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        bus.wr_valid_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.commit_i = 1'b0;
`ifdef FIR_COEFF_LOADER_READBACK_EN
        bus.rd_addr_i = '0; bus.rd_sel_i = '0;
`endif
        #1 rstn = 1'b0;
        model_reset();
        chk_on = 1'b1;
        step(2);
        chk("rst_coeff2", bus.coeff2_o, 18'h00100);
        chk("rst_dsp", 18'(bus.dsp_rst_o), 18'd1);
        chk("rst_ready", 18'(bus.wr_ready_o), 18'd0);

        // Post-reset flush: 8 cycles of dsp_rst, no done.
        rstn = 1'b1;
        step(7);
        chk("prf_dsp7", 18'(bus.dsp_rst_o), 18'd1);
        chk("prf_ready7", 18'(bus.wr_ready_o), 18'd0);
        step(1);
        chk("prf_ready9", 18'(bus.wr_ready_o), 18'd1);
        chk("prf_dsp9", 18'(bus.dsp_rst_o), 18'd0);
        chk("prf_done", 18'(bus.done_o), 18'd0);

        // Load 1,2,3,-4 and commit.
        wr(2'd0, 18'd1); wr(2'd1, 18'd2); wr(2'd2, 18'd3); wr(2'd3, 18'h3FFFC);
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        chk("apply_c0_old", bus.coeff0_o, 18'd0);
        chk("apply_dsp", 18'(bus.dsp_rst_o), 18'd0);
        tick();
        chk("c0", bus.coeff0_o, 18'd1);
        chk("c1", bus.coeff1_o, 18'd2);
        chk("c2", bus.coeff2_o, 18'd3);
        chk("c3", bus.coeff3_o, 18'h3FFFC);
        chk("fl_dsp1", 18'(bus.dsp_rst_o), 18'd1);
        step(7);
        chk("fl_dsp8", 18'(bus.dsp_rst_o), 18'd1);
        chk("fl_done8", 18'(bus.done_o), 18'd0);
        step(1);
        chk("fl_done9", 18'(bus.done_o), 18'd1);
        chk("fl_ready9", 18'(bus.wr_ready_o), 18'd1);

        // Write bypass into the commit.
        bus.wr_valid_i = 1'b1; bus.wr_addr_i = 2'd1; bus.wr_data_i = 18'd5; bus.commit_i = 1'b1;
        tick();
        bus.wr_valid_i = 1'b0; bus.commit_i = 1'b0;
        tick();
        chk("byp_c1", bus.coeff1_o, 18'd5);
        step(8);
        chk("byp_done", 18'(bus.done_o), 18'd1);

        // Clean commit: immediate done, no flush.
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        chk("clean_done", 18'(bus.done_o), 18'd1);
        chk("clean_dsp", 18'(bus.dsp_rst_o), 18'd0);
        chk("clean_c1", bus.coeff1_o, 18'd5);
        tick();
        chk("clean_done2", 18'(bus.done_o), 18'd0);

        // Held write across a flush; commit during flush ignored.
        bus.wr_valid_i = 1'b1; bus.wr_addr_i = 2'd0; bus.wr_data_i = 18'd9; bus.commit_i = 1'b1;
        tick();
        bus.commit_i = 1'b0;
        bus.wr_addr_i = 2'd2; bus.wr_data_i = 18'h00ABC;
        step(3);
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        step(4);
        chk("hold_ready8", 18'(bus.wr_ready_o), 18'd0);
        step(1);
        chk("hold_ready9", 18'(bus.wr_ready_o), 18'd1);
        tick();
        bus.wr_valid_i = 1'b0;
        chk("hold_c2_active", bus.coeff2_o, 18'd3);
        chk("hold_c0", bus.coeff0_o, 18'd9);
        step(2);
        chk("hold_busy", 18'(bus.busy_o), 18'd0);
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        tick();
        chk("hold_c2_new", bus.coeff2_o, 18'h00ABC);
        step(8);
        chk("hold_done", 18'(bus.done_o), 18'd1);

        // Reset in the middle of a flush.
        wr(2'd0, 18'd7);
        bus.commit_i = 1'b1; tick(); bus.commit_i = 1'b0;
        tick();
        chk("mid_c0", bus.coeff0_o, 18'd7);
        step(2);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_c0", bus.coeff0_o, 18'd0);
        chk("mid_rst_c2", bus.coeff2_o, 18'h00100);
        chk("mid_rst_dsp", 18'(bus.dsp_rst_o), 18'd1);
        chk("mid_rst_ready", 18'(bus.wr_ready_o), 18'd0);
        step(2);
        rstn = 1'b1;
        step(7);
        chk("mid_dsp8", 18'(bus.dsp_rst_o), 18'd1);
        step(1);
        chk("mid_ready9", 18'(bus.wr_ready_o), 18'd1);
        chk("mid_done9", 18'(bus.done_o), 18'd0);
        step(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
